// File: rtl/lsu_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : lsu_mem_pkg                                                |
// | Shared access-size encodings, controller state encoding and the      |
// | byte-lane mask helper used by the LSU memory front end.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package lsu_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_DATA = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   // Bytes of the 32-bit word touched by an access of the given size.
   function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << addr_lo;
         SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : lsu_mem_ctrl_if                                          |
// | Request/response handshake plus the single-port memory bus seen by   |
// | the LSU memory controller. slave = controller side, master = the     |
// | requester together with the memory.                                  |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface lsu_mem_ctrl_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [1:0]                req_size;
   logic                      req_unsigned;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [31:0]               req_wdata;
   logic                      rsp_valid;
   logic [31:0]               rsp_rdata;
   logic                      rsp_err;
   logic                      mem_en;
   logic                      mem_wr;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]               mem_wdata;
   logic [31:0]               mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lsu_mem_align                                               |
// | Combinational lane logic: extracts and extends load data, and merges |
// | replicated store data into the read word for sub-word stores.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module lsu_mem_align
   import lsu_mem_pkg::*;
(
   input  wire logic [1:0]  i_size,
   input  wire logic [1:0]  i_addr_lo,
   input  wire logic        i_unsigned,
   input  wire logic [31:0] i_rdata,
   input  wire logic [31:0] i_wdata,
   output logic      [31:0] o_load_data,
   output logic      [31:0] o_merged
);

   logic [3:0]  w_mask;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_rep;

   assign w_mask = byte_mask(i_size, i_addr_lo);
   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   // Select the addressed byte lane of the read word.
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
   end

   // Sign- or zero-extend the selected lane to a full word.
   always_comb begin
      o_load_data = i_rdata;
      case (i_size)
         SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_load_data = i_rdata;
      endcase
   end

   // Replicate right-aligned store data into every lane it could occupy.
   always_comb begin
      w_rep = i_wdata;
      case (i_size)
         SZ_BYTE: w_rep = {4{i_wdata[7:0]}};
         SZ_HALF: w_rep = {2{i_wdata[15:0]}};
         default: w_rep = i_wdata;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign o_merged[8*gi +: 8] = w_mask[gi] ? w_rep[8*gi +: 8] : i_rdata[8*gi +: 8];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : lsu_mem_ctrl                                                |
// | Load/store front end for a single-port 32-bit data memory with       |
// | 1-cycle read latency. Sub-word stores are read-modify-write; loads   |
// | are sign/zero-extended; one response per accepted request.           |
// | Option : LSU_MEM_MISALIGN_ERR_EN - misaligned half/word accesses     |
// |          return rsp_err without touching memory; otherwise the low   |
// |          address bits are forced to alignment.                       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module lsu_mem_ctrl
   import lsu_mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10
)(
   input  wire logic       clk,
   input  wire logic       reset_n,
   lsu_mem_ctrl_if.slave   bus
);

   state_t                    r_state;
   state_t                    w_state_next;
   logic                      r_we;
   logic [1:0]                r_size;
   logic                      r_unsigned;
   logic [1:0]                r_addr_lo;
   logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]               r_wdata;
   logic [31:0]               r_rsp_rdata;

   logic                      w_req_fire;
   logic [1:0]                w_req_size;
   logic [1:0]                w_addr_lo_aligned;
   logic                      w_err_req;
   logic                      w_mem_en;
   logic                      w_mem_wr;
   logic                      w_req_ready;
   logic                      w_rsp_valid;
   logic [31:0]               w_load_data;
   logic [31:0]               w_merged;
   logic                      w_unused_addr;

   // Address bits above the word index are deliberately ignored.
   assign w_unused_addr = ^bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

   assign w_req_fire = bus.req_valid && (r_state == ST_IDLE);
   assign w_req_size = (bus.req_size == SZ_RSVD) ? SZ_WORD : bus.req_size;

   // Lane offset after alignment; misaligned requests either error out or use this.
   always_comb begin
      w_addr_lo_aligned = bus.req_addr[1:0];
      case (w_req_size)
         SZ_HALF: w_addr_lo_aligned = {bus.req_addr[1], 1'b0};
         SZ_WORD: w_addr_lo_aligned = 2'b00;
         default: w_addr_lo_aligned = bus.req_addr[1:0];
      endcase
   end

`ifdef LSU_MEM_MISALIGN_ERR_EN
   logic r_err;

   assign w_err_req = ((w_req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((w_req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

   // Remember whether the accepted request is a misaligned-access error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_err <= 1'b0;
      else if (w_req_fire) r_err <= w_err_req;
   end

   assign bus.rsp_err = r_err && (r_state == ST_RESP);
`else
   assign w_err_req   = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state and memory/handshake strobes.
   always_comb begin
      w_state_next = r_state;
      w_mem_en     = 1'b0;
      w_mem_wr     = 1'b0;
      w_req_ready  = 1'b0;
      w_rsp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               if (w_err_req)                            w_state_next = ST_RESP;
               else if (bus.req_we && (w_req_size == SZ_WORD)) w_state_next = ST_WR;
               else                                      w_state_next = ST_RD;
            end
         end
         ST_RD: begin
            w_mem_en     = 1'b1;
            w_state_next = ST_DATA;
         end
         ST_DATA: begin
            w_state_next = r_we ? ST_WR : ST_RESP;
         end
         ST_WR: begin
            w_mem_en     = 1'b1;
            w_mem_wr     = 1'b1;
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            w_rsp_valid  = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Capture the request on handshake; fold the read word into store data in DATA.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_addr_lo  <= 2'b00;
         r_mem_addr <= '0;
         r_wdata    <= '0;
      end else if (w_req_fire) begin
         r_we       <= bus.req_we;
         r_size     <= w_req_size;
         r_unsigned <= bus.req_unsigned;
         r_addr_lo  <= w_addr_lo_aligned;
         r_mem_addr <= bus.req_addr[MEM_ADDR_WIDTH+1:2];
         r_wdata    <= bus.req_wdata;
      end else if ((r_state == ST_DATA) && r_we) begin
         r_wdata    <= w_merged;
      end
   end

   // Load result is latched on entry to RESP; stores and errors return zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_rsp_rdata <= '0;
      else if (w_state_next == ST_RESP)
         r_rsp_rdata <= ((r_state == ST_DATA) && !r_we) ? w_load_data : 32'd0;
   end

   lsu_mem_align u_align (
      .i_size      (r_size),
      .i_addr_lo   (r_addr_lo),
      .i_unsigned  (r_unsigned),
      .i_rdata     (bus.mem_rdata),
      .i_wdata     (r_wdata),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.mem_en    = w_mem_en;
   assign bus.mem_wr    = w_mem_wr;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Testbench : tb_lsu_mem_ctrl                                          |
// | Drives lsu_mem_ctrl against a behavioural 1-cycle-latency memory;    |
// | response data is checked against a queue of expected results.        |
// | Honours LSU_MEM_MISALIGN_ERR_EN for the misaligned-access vectors.   |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_lsu_mem_ctrl;
   import lsu_mem_pkg::*;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic        exp_mem;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic reset_n;

   lsu_mem_ctrl_if #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10)) bus ();

   lsu_mem_ctrl #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_pulses = 0;
   exp_t exp_q[$];
   vec_t vecs[$];

   logic [31:0] mem [0:1023];
   logic [31:0] r_mem_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port memory, read data valid the cycle after en&~wr.
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_wr)  mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_wr) r_mem_rdata       <= mem[bus.mem_addr];
   end
   assign bus.mem_rdata = r_mem_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: every response pulse is compared with the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && bus.rsp_valid) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata 0x%08h with nothing expected", bus.rsp_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic add(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input logic exp_mem);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_mem = exp_mem;
      vecs.push_back(v);
   endtask

   task automatic drive_req(input vec_t v);
      bus.req_we       = v.we;
      bus.req_size     = v.size;
      bus.req_unsigned = v.uns;
      bus.req_addr     = v.addr;
      bus.req_wdata    = v.wdata;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   n;
      logic seen;
      logic mem_seen;
      logic mem_bad;
      exp_t e;
      n = 0; seen = 1'b0; mem_seen = 1'b0; mem_bad = 1'b0;
      @(negedge clk);
      drive_req(v);
      bus.req_valid = 1'b1;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      exp_q.push_back(e);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.mem_en) begin
            mem_seen = 1'b1;
            if (bus.mem_addr != v.addr[11:2]) mem_bad = 1'b1;
         end
         if (bus.rsp_valid) seen = 1'b1;
      end
      check($sformatf("v%0d_rsp_seen", idx), {31'd0, seen}, 32'd1);
      check($sformatf("v%0d_latency", idx), n, v.exp_lat);
      check($sformatf("v%0d_mem_access", idx), {31'd0, mem_seen}, {31'd0, v.exp_mem});
      check($sformatf("v%0d_mem_addr_ok", idx), {31'd0, mem_bad}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_rsp_one_cycle", idx), {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   initial begin
      int   p0;
      int   low;
      int   n;
      logic rdy;
      vec_t va;
      vec_t vb;
      exp_t e;

      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      r_mem_rdata      = 32'd0;
      reset_n          = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'd0;
      bus.req_wdata    = 32'd0;

      //            we    size     uns   addr   wdata         exp_rdata     err  lat mem
      add(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1'b1);
      add(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1'b1);
      add(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h12345680, 32'h00000000, 1'b0, 4, 1'b1);
      add(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0, 3, 1'b1);
      add(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1'b1);
      add(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0,        32'h00000080, 1'b0, 3, 1'b1);
      add(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hABCD1234, 32'h00000000, 1'b0, 4, 1'b1);
      add(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        32'h123480EF, 1'b0, 3, 1'b1);
      add(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        32'h00001234, 1'b0, 3, 1'b1);
      add(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0,        32'hFFFF80EF, 1'b0, 3, 1'b1);
      add(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0,        32'h000080EF, 1'b0, 3, 1'b1);
      add(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'h00000012, 1'b0, 3, 1'b1);
      add(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0, 3, 1'b1);
`ifdef LSU_MEM_MISALIGN_ERR_EN
      add(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0,        32'h00000000, 1'b1, 1, 1'b0);
      add(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0,        32'h00000000, 1'b1, 1, 1'b0);
`else
      add(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0,        32'h123480EF, 1'b0, 3, 1'b1);
      add(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0,        32'h00001234, 1'b0, 3, 1'b1);
`endif
      add(1'b1, SZ_RSVD, 1'b0, 32'h20, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 1'b1);
      add(1'b0, SZ_RSVD, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1'b1);
      add(1'b1, SZ_BYTE, 1'b0, 32'h20, 32'hFFFFFFAA, 32'h00000000, 1'b0, 4, 1'b1);
      add(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00005555, 32'h00000000, 1'b0, 4, 1'b1);
      add(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        32'h5555F0AA, 1'b0, 3, 1'b1);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
      check("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
      check("rst_mem_wr",    {31'd0, bus.mem_wr}, 32'd0);
      check("rst_mem_addr",  {22'd0, bus.mem_addr}, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      reset_n = 1'b1;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Two loads presented back to back with req_valid held high.
      p0 = n_pulses;
      va = vecs[0]; va.we = 1'b0; va.size = SZ_WORD; va.addr = 32'h10;
      vb = va;      vb.addr = 32'h20;
      @(negedge clk);
      drive_req(va);
      bus.req_valid = 1'b1;
      e.rdata = 32'h123480EF; e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1 drive_req(vb);
      e.rdata = 32'h5555F0AA; e.err = 1'b0;
      exp_q.push_back(e);
      low = 0; n = 0; rdy = 1'b0;
      while (!rdy && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.req_ready) rdy = 1'b1;
         else               low++;
      end
      check("b2b_ready_low_cycles", low, 3);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("b2b_pulses", n_pulses - p0, 2);
      check("b2b_queue_drained", exp_q.size(), 0);

      // Reset asserted while an SB sits in DATA: no write, no response.
      p0 = n_pulses;
      va = vecs[0]; va.we = 1'b1; va.size = SZ_BYTE; va.addr = 32'h21; va.wdata = 32'h77;
      @(negedge clk);
      drive_req(va);
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("abort_rd_mem_en", {31'd0, bus.mem_en}, 32'd1);
      @(negedge clk);
      check("abort_data_mem_en", {31'd0, bus.mem_en}, 32'd0);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
      check("abort_mem_word", mem[8], 32'h5555F0AA);
      repeat (4) @(negedge clk);
      check("abort_no_rsp", n_pulses - p0, 0);
      va.we = 1'b0; va.size = SZ_WORD; va.addr = 32'h20;
      va.exp_rdata = 32'h5555F0AA; va.exp_err = 1'b0; va.exp_lat = 3; va.exp_mem = 1'b1;
      run_vec(99, va);

      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
